ctrl_path_arbiter: RTL

//  Packet-atomic round-robin arbiter that merges NUM_SRC control-path AXI-Stream sources

---
 rtl/ctrl_path_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/ctrl_path_arbiter.sv
// ctrl_path_arbiter: packet-atomic round-robin merge of control-path AXI-Stream sources
// into the stage-chain configuration stream, truncating runaway packets.
module ctrl_path_arbiter #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_SRC              = 4,
   parameter int MAX_PKT_BEATS        = 64
) (
   input  logic                                      axis_clk,
   input  logic                                      aresetn,
   input  logic [NUM_SRC*C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [NUM_SRC*C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic [NUM_SRC*C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [NUM_SRC-1:0]                        s_axis_tvalid,
   input  logic [NUM_SRC-1:0]                        s_axis_tlast,
   output logic [NUM_SRC-1:0]                        s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]            c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]           c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]          c_m_axis_tkeep,
   output logic                                      c_m_axis_tvalid,
   output logic                                      c_m_axis_tlast,
   output logic [31:0]                               pkt_count,
   output logic                                      trunc_err
);
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int UW = C_S_AXIS_TUSER_WIDTH;
   localparam int KW = DW / 8;
   localparam int GW = $clog2(NUM_SRC);
   localparam int BW = $clog2(MAX_PKT_BEATS + 1);

   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [GW-1:0] grant, rr_pick;
   logic [BW-1:0] beat_cnt;
   logic          any_valid, beat_xfer, beat_last, beat_trunc, fwd;

   assign any_valid  = |s_axis_tvalid;
   assign beat_xfer  = (state != IDLE) && s_axis_tvalid[grant];
   assign beat_last  = s_axis_tlast[grant];
   assign fwd        = (state == XFER) && beat_xfer;
   assign beat_trunc = fwd && !beat_last && (beat_cnt == BW'(MAX_PKT_BEATS - 1));

   // scan downward so the nearest valid source after the previous grant wins
   always_comb begin
      logic [GW-1:0] idx;
      idx     = '0;
      rr_pick = grant;
      for (int i = NUM_SRC; i >= 1; i--) begin
         idx = GW'((int'(grant) + i) % NUM_SRC);
         if (s_axis_tvalid[idx]) rr_pick = idx;
      end
   end

   always_ff @(posedge axis_clk or negedge aresetn)
      if (!aresetn) state <= IDLE;
      else          state <= state_nxt;

   always_comb
      state_nxt = (state == IDLE) ? (any_valid ? XFER : IDLE) :
                  (beat_xfer && beat_last) ? IDLE :
                  (state == DRAIN || beat_trunc) ? DRAIN : XFER;

   always_comb
      s_axis_tready = (state != IDLE) ? (NUM_SRC'(1) << grant) : '0;

   always_ff @(posedge axis_clk or negedge aresetn)
      if (!aresetn) begin
         grant           <= GW'(NUM_SRC - 1);
         beat_cnt        <= '0;
         c_m_axis_tdata  <= '0;
         c_m_axis_tuser  <= '0;
         c_m_axis_tkeep  <= '0;
         c_m_axis_tvalid <= 1'b0;
         c_m_axis_tlast  <= 1'b0;
         pkt_count       <= '0;
         trunc_err       <= 1'b0;
      end else begin
         if (state == IDLE && any_valid) grant <= rr_pick;
         if (fwd) beat_cnt <= (beat_last || beat_trunc) ? '0 : beat_cnt + 1'b1;
         c_m_axis_tvalid <= fwd;
         if (fwd) begin
            c_m_axis_tdata <= s_axis_tdata[int'(grant)*DW +: DW];
            c_m_axis_tuser <= s_axis_tuser[int'(grant)*UW +: UW];
            c_m_axis_tkeep <= s_axis_tkeep[int'(grant)*KW +: KW];
            c_m_axis_tlast <= beat_last || beat_trunc;
         end
         if (fwd && (beat_last || beat_trunc)) pkt_count <= pkt_count + 32'd1;
         if (beat_trunc) trunc_err <= 1'b1;
      end
endmodule
